fifo_sync_flags: RTL and testbench

Parametrised single-clock synchronous FIFO that succeeds the basic push/pull FIFO.
- Keeps the push/pull/full/empty contract.
- Adds an occupancy count and programmable almost-full/almost-empty flags.
- Adds sticky overflow/underflow error flags (in RTL, not bench assertions) and a selectable first-word-fall-through (FWFT) read mode.
- Sits between producer/consumer agents in the FIFO VIP environment; non-power-of-two depths are supported.

---
 rtl/fifo_pkg.sv | 36 +++
 rtl/fifoif.sv | 47 ++++
 rtl/fifo_mem.sv | 28 ++
 rtl/fifo_sync_flags.sv | 111 +++++++++++
 tb/tb_fifo_sync_flags.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the flagged synchronous FIFO and its VIP agents.
package fifo_pkg;

  typedef enum logic [0:0] {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // Status after reset: nothing stored, no errors latched.
  localparam fifo_status_t StatusRst = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1,
    overflow:     1'b0,
    underflow:    1'b0
  };

  function automatic int unsigned cnt_w(input int unsigned entries);
    return $clog2(entries + 1);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/fifoif.sv
// FIFO handshake bundle: push/pull data path plus occupancy, threshold and error status.
interface fifoif #(
  parameter int unsigned busw    = 32,
  parameter int unsigned entries = 31
) ();
  import fifo_pkg::*;

  localparam int unsigned CntW = cnt_w(entries);

  logic            push;
  logic [busw-1:0] datain;
  logic            pull;
  logic [busw-1:0] dataout;
  logic            full;
  logic            empty;
  logic            almost_full;
  logic            almost_empty;
  logic [CntW-1:0] count;
  logic            overflow;
  logic            underflow;
  logic            err_clr;

  function automatic fifo_status_t status();
    return '{
      full:         full,
      empty:        empty,
      almost_full:  almost_full,
      almost_empty: almost_empty,
      overflow:     overflow,
      underflow:    underflow
    };
  endfunction

  // FIFO side.
  modport fif (
    input  push, datain, pull, err_clr,
    output dataout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  // Producer/consumer agent side.
  modport agent (
    output push, datain, pull, err_clr,
    input  dataout, full, empty, almost_full, almost_empty, count, overflow, underflow,
    import status
  );

endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: entries x busw registers, one synchronous write port, one asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned busw    = 32,
  parameter int unsigned entries = 31,
  localparam int unsigned PtrW   = ptr_w(entries)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [PtrW-1:0] waddr_i,
  input  logic [busw-1:0] wdata_i,
  input  logic [PtrW-1:0] raddr_i,
  output logic [busw-1:0] rdata_o
);

  // Contents are deliberately left out of reset.
  logic [busw-1:0] mem_q [entries];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky error flags
// and a selectable registered or first-word-fall-through read port.
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int unsigned busw      = 32,
  parameter int unsigned entries   = 31,
  parameter int unsigned af_thresh = entries - 4,
  parameter int unsigned ae_thresh = 4,
  parameter int unsigned fwft      = 0
) (
  input logic clk,
  input logic rst,
  fifoif.fif  bus
);

  localparam int unsigned CntW    = cnt_w(entries);
  localparam int unsigned PtrW    = ptr_w(entries);
  localparam fifo_mode_e  Mode    = (fwft != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [PtrW-1:0] PtrLast = PtrW'(entries - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(entries);
  localparam logic [CntW-1:0] AfLevel = CntW'(af_thresh);
  localparam logic [CntW-1:0] AeLevel = CntW'(ae_thresh);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  fifo_status_t    status_q, status_d;
  logic            push_ok, pull_ok;
  logic [busw-1:0] rdata;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  assign push_ok = bus.push & ~status_q.full;
  assign pull_ok = bus.pull & ~status_q.empty;

  always_comb begin
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pull_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    count_d = count_q;
    case ({push_ok, pull_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    status_d.full         = (count_d == CntFull);
    status_d.empty        = (count_d == '0);
    status_d.almost_full  = (count_d >= AfLevel);
    status_d.almost_empty = (count_d <= AeLevel);
    // A fresh error beats a coincident clear.
    status_d.overflow     = (bus.push & status_q.full) | (status_q.overflow & ~bus.err_clr);
    status_d.underflow    = (bus.pull & status_q.empty) | (status_q.underflow & ~bus.err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      status_q <= StatusRst;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      status_q <= status_d;
    end
  end

  fifo_mem #(
    .busw    (busw),
    .entries (entries)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.datain),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  if (Mode == FIFO_STD) begin : g_std
    logic [busw-1:0] dout_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q <= '0;
      end else if (pull_ok) begin
        dout_q <= rdata;
      end
    end

    assign bus.dataout = dout_q;
  end else begin : g_fwft
    // Head word is shown as soon as it is stored; zero while nothing is held.
    assign bus.dataout = status_q.empty ? '0 : rdata;
  end

  assign bus.full         = status_q.full;
  assign bus.empty        = status_q.empty;
  assign bus.almost_full  = status_q.almost_full;
  assign bus.almost_empty = status_q.almost_empty;
  assign bus.overflow     = status_q.overflow;
  assign bus.underflow    = status_q.underflow;
  assign bus.count        = count_q;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Drives a registered-read and an FWFT instance in lockstep against a queue-based model.
module tb_fifo_sync_flags;
  import fifo_pkg::*;

  localparam int unsigned Busw    = 32;
  localparam int unsigned Entries = 31;
  localparam int unsigned AfThr   = 27;
  localparam int unsigned AeThr   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifoif #(.busw(Busw), .entries(Entries)) if_std ();
  fifoif #(.busw(Busw), .entries(Entries)) if_fwf ();

  fifo_sync_flags #(
    .busw(Busw), .entries(Entries), .af_thresh(AfThr), .ae_thresh(AeThr), .fwft(0)
  ) u_std (
    .clk (clk),
    .rst (rst),
    .bus (if_std.fif)
  );

  fifo_sync_flags #(
    .busw(Busw), .entries(Entries), .af_thresh(AfThr), .ae_thresh(AeThr),
    .fwft(int'(FIFO_FWFT))
  ) u_fwft (
    .clk (clk),
    .rst (rst),
    .bus (if_fwf.fif)
  );

  int total = 0;
  int bad   = 0;

  logic [Busw-1:0] model_q [$];  // words currently held
  logic [Busw-1:0] exp_q   [$];  // words popped, awaiting the registered read port
  logic            m_ovf = 1'b0;
  logic            m_unf = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    int unsigned     sz;
    logic [5:0]      fl;
    logic [Busw-1:0] head;
    sz   = model_q.size();
    fl   = {sz == Entries, sz == 0, sz >= AfThr, sz <= AeThr, m_ovf, m_unf};
    head = (sz != 0) ? model_q[0] : '0;
    chk("std_count", 64'(if_std.count), 64'(sz));
    chk("std_flags", {if_std.full, if_std.empty, if_std.almost_full, if_std.almost_empty,
                      if_std.overflow, if_std.underflow}, 64'(fl));
    chk("fwft_count", 64'(if_fwf.count), 64'(sz));
    chk("fwft_flags", {if_fwf.full, if_fwf.empty, if_fwf.almost_full, if_fwf.almost_empty,
                       if_fwf.overflow, if_fwf.underflow}, 64'(fl));
    chk("fwft_dout", 64'(if_fwf.dataout), 64'(head));
  endtask

  // One clock: drive at negedge+1, update the model at posedge, check at the next negedge.
  task automatic step(input logic p, input logic [Busw-1:0] d, input logic q, input logic c,
                      input logic r);
    int unsigned sz;
    rst           = r;
    if_std.push   = p;  if_fwf.push   = p;
    if_std.datain = d;  if_fwf.datain = d;
    if_std.pull   = q;  if_fwf.pull   = q;
    if_std.err_clr = c; if_fwf.err_clr = c;
    sz = model_q.size();
    @(posedge clk);
    if (r) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (p && sz == Entries) m_ovf = 1'b1;
      else if (c)             m_ovf = 1'b0;
      if (q && sz == 0)       m_unf = 1'b1;
      else if (c)             m_unf = 1'b0;
      if (q && sz != 0)       exp_q.push_back(model_q.pop_front());
      if (p && sz != Entries) model_q.push_back(d);
    end
    @(negedge clk);
    check_state();
    #1;
  endtask

  // Registered read port monitor: a pop seen before an edge must show its word after it.
  initial begin : monitor
    logic            pend_pop;
    logic            pend_rst;
    logic [Busw-1:0] last;
    pend_pop = 1'b0;
    pend_rst = 1'b0;
    last     = '0;
    forever begin
      @(negedge clk);
      if (pend_rst) begin
        last = '0;
      end else if (pend_pop) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL std_pop actual=unexpected_pop required=no_pop t=%0t", $time);
        end else begin
          last = exp_q.pop_front();
        end
      end
      chk("std_dout", 64'(if_std.dataout), 64'(last));
      #2;
      pend_rst = rst;
      pend_pop = if_std.pull && !if_std.empty;
    end
  end

  initial begin : main
    logic            p, q, c, r;
    logic [Busw-1:0] d;
    int unsigned     bias;
    rst = 1'b1;
    if_std.push = 1'b0; if_fwf.push = 1'b0;
    if_std.pull = 1'b0; if_fwf.pull = 1'b0;
    if_std.datain = '0; if_fwf.datain = '0;
    if_std.err_clr = 1'b0; if_fwf.err_clr = 1'b0;
    @(negedge clk);
    #1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Fill to full, one extra push, then drain.
    for (int i = 1; i <= 31; i++) step(1'b1, Busw'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 31; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Preload 5, then steady push+pull so both pointers wrap several times.
    for (int i = 0; i < 5; i++) step(1'b1, Busw'(32'h100 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b1, Busw'(32'h200 + i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Threshold walk up and back down.
    for (int i = 0; i < 28; i++) step(1'b1, Busw'(32'h300 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 28; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Underflow, clear, clear racing a new underflow.
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Single word into an empty FIFO, then popped.
    step(1'b1, 32'hA5A5, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Reset during push+pull with 12 held.
    for (int i = 0; i < 12; i++) step(1'b1, Busw'(32'h400 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h55, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h78, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Random traffic with phases biased toward filling, draining and balance.
    for (int i = 0; i < 1500; i++) begin
      bias = (i / 250) % 3;
      p = (bias == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      q = (bias == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 299) == 0);
      d = $urandom();
      step(p, d, q, c, r);
    end

    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
